// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display slice.
package display_pkg;

  // Segment bus is active-low {g,f,e,d,c,b,a}; all ones means every segment off.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef logic [3:0] digit_t;
  typedef logic [3:0] brightness_t;

endpackage

// File: rtl/scan_display_ctrl_if.sv
// Display request/drive bundle: the master supplies digits and controls, the slave drives the LEDs.
interface scan_display_ctrl_if
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_blank;
  brightness_t             brightness;
  logic                    enable;

  logic [NUM_DIGITS-1:0]   anodes;
  logic [6:0]              seg;
  logic                    dp_n;
  logic                    frame_tick;

  modport master (
    output data, dp, blink_mask, lz_blank, brightness, enable,
    input  anodes, seg, dp_n, frame_tick
  );

  modport slave (
    input  data, dp, blink_mask, lz_blank, brightness, enable,
    output anodes, seg, dp_n, frame_tick
  );

endinterface

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low 7-segment pattern {g..a}; purely combinational.
module hex_to_7seg
  import display_pkg::*;
(
  input  digit_t     digit,
  output logic [6:0] seg
);

  always_comb begin
    unique case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/scan_display_ctrl.sv
// Time-multiplexed 7-segment scanner with frame-synchronous shadowing, PWM brightness,
// leading-zero suppression and per-digit blink. All LED outputs are registered.
module scan_display_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 27000,
  parameter int BLANK_CYCLES = 270,
  parameter int BLINK_FRAMES = 250
) (
  input  logic              clk,
  input  logic              rst_n,
  scan_display_ctrl_if.slave bus
);

  localparam int SLOT_W = $clog2(DIGIT_CYCLES);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SLICE  = DIGIT_CYCLES / 16;

  logic [SLOT_W-1:0]       slot_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [FRM_W-1:0]        frame_cnt;
  logic                    blink_phase;
  brightness_t             bright_q;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_blink;

  logic slot_wrap;
  logic frame_wrap;

  assign slot_wrap  = (slot_cnt == SLOT_W'(DIGIT_CYCLES - 1));
  assign frame_wrap = slot_wrap && (digit_idx == IDX_W'(NUM_DIGITS - 1));

  // NOTE: every flop below is assigned with <= so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt     <= '0;
      digit_idx    <= '0;
      frame_cnt    <= '0;
      blink_phase  <= 1'b0;
      bright_q     <= '0;
      // NOTE: the shadow array is a handful of flops, not a RAM, so it takes the reset too.
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blink <= '0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (slot_wrap)
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      if (slot_cnt == '0)
        bright_q <= bus.brightness;
      if (frame_wrap) begin
        shadow_data  <= bus.data;
        shadow_dp    <= bus.dp;
        shadow_blink <= bus.blink_mask;
        if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  digit_t                sel_digit;
  logic [6:0]            dec_seg;
  brightness_t           bright_eff;
  logic [31:0]           win_end;
  logic                  in_window;
  logic                  all_zero;
  logic [NUM_DIGITS-1:0] lz_dark;
  logic                  show;
  logic [NUM_DIGITS-1:0] anodes_d;
  logic [6:0]            seg_d;
  logic                  dp_n_d;

  assign sel_digit = shadow_data[4*digit_idx +: 4];

  hex_to_7seg u_hex_to_7seg (
    .digit (sel_digit),
    .seg   (dec_seg)
  );

  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    bright_eff = (slot_cnt == '0) ? bus.brightness : bright_q;
    win_end    = 32'(BLANK_CYCLES) + (32'(bright_eff) + 32'd1) * 32'(SLICE);
    if (win_end > 32'(DIGIT_CYCLES))
      win_end = 32'(DIGIT_CYCLES);
    in_window = (32'(slot_cnt) >= 32'(BLANK_CYCLES)) && (32'(slot_cnt) < win_end);

    // Walk from the most significant digit down; digit 0 is never suppressed.
    lz_dark  = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero   = all_zero && (shadow_data[4*i +: 4] == 4'h0);
      lz_dark[i] = all_zero && bus.lz_blank;
    end

    show = bus.enable && in_window && !(blink_phase && shadow_blink[digit_idx]);

    anodes_d = '1;
    seg_d    = SEG_OFF;
    dp_n_d   = 1'b1;
    if (show) begin
      if (!lz_dark[digit_idx]) begin
        anodes_d = ~(NUM_DIGITS'(1) << digit_idx);
        seg_d    = dec_seg;
        dp_n_d   = ~shadow_dp[digit_idx];
      end else if (shadow_dp[digit_idx]) begin
        // Suppressed zero still carries its decimal point.
        anodes_d = ~(NUM_DIGITS'(1) << digit_idx);
        dp_n_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.anodes     <= '1;
      bus.seg        <= SEG_OFF;
      bus.dp_n       <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.anodes     <= anodes_d;
      bus.seg        <= seg_d;
      bus.dp_n       <= dp_n_d;
      bus.frame_tick <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed bench for scan_display_ctrl with short slots (64 clk) so whole frames run quickly.
module tb_scan_display_ctrl;
  import display_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  scan_display_ctrl_if #(.NUM_DIGITS(4)) bus ();

  scan_display_ctrl #(
    .NUM_DIGITS   (4),
    .DIGIT_CYCLES (64),
    .BLANK_CYCLES (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Posedges since reset release; after posedge k the outputs show slot state g = k-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  localparam logic [6:0]  S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19, S5 = 7'h12;
  localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b1};

  function automatic logic [11:0] lit(input logic [3:0] an, input logic [6:0] s, input logic d);
    return {an, s, d};
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step to the negedge where the registered outputs reflect global slot cycle g.
  task automatic go(input int g);
    while (cyc < g + 1) @(negedge clk);
    if (cyc != g + 1) begin
      errors++;
      $error("FAIL sync@%0d: observed cycle %0d expected %0d", g, cyc, g + 1);
    end
  endtask

  task automatic at(input int g, input string tag, input logic [11:0] exp);
    go(g);
    chk($sformatf("%s@%0d", tag, g), {bus.anodes, bus.seg, bus.dp_n}, exp);
  endtask

  task automatic ft_at(input int g, input logic exp);
    go(g);
    chk($sformatf("frame_tick@%0d", g), {11'b0, bus.frame_tick}, {11'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data       = 16'h1234;
    bus.dp         = 4'b0000;
    bus.blink_mask = 4'b0000;
    bus.lz_blank   = 1'b0;
    bus.brightness = 4'd15;
    bus.enable     = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", {bus.anodes, bus.seg, bus.dp_n}, DARK);
    chk("reset_ft", {11'b0, bus.frame_tick}, 12'd0);
    rst_n = 1'b1;

    // Frame 0 shows the reset shadow (all zeros); data 1234 lands at the first wrap.
    at(1,   "blank_window", DARK);
    at(2,   "f0_digit0",    lit(4'b1110, S0, 1'b1));
    ft_at(254, 1'b0);
    ft_at(255, 1'b1);
    at(255, "f0_last",      lit(4'b0111, S0, 1'b1));
    ft_at(256, 1'b0);
    at(256, "slot0_dark",   DARK);
    at(258, "d0_4",         lit(4'b1110, S4, 1'b1));
    at(319, "d0_end",       lit(4'b1110, S4, 1'b1));
    at(320, "d1_start",     DARK);
    at(322, "d1_3",         lit(4'b1101, S3, 1'b1));
    at(386, "d2_2",         lit(4'b1011, S2, 1'b1));
    at(450, "d3_1",         lit(4'b0111, S1, 1'b1));

    // Brightness is only taken at slot start.
    go(460); bus.brightness = 4'd0;
    at(500, "bright_hold",  lit(4'b0111, S1, 1'b1));
    at(514, "b0_first",     lit(4'b1110, S4, 1'b1));
    at(517, "b0_last",      lit(4'b1110, S4, 1'b1));
    at(518, "b0_off",       DARK);
    go(520); bus.brightness = 4'd7;
    at(578, "b7_first",     lit(4'b1101, S3, 1'b1));
    at(609, "b7_last",      lit(4'b1101, S3, 1'b1));
    at(610, "b7_off",       DARK);
    bus.brightness = 4'd15;

    at(642, "en_on",        lit(4'b1011, S2, 1'b1));
    at(650, "en_before",    lit(4'b1011, S2, 1'b1));
    bus.enable = 1'b0;
    at(651, "en_off",       DARK);
    go(660); bus.enable = 1'b1;
    at(661, "en_back",      lit(4'b1011, S2, 1'b1));

    // dp and data 1111 are shadowed at the wrap after g=767; 2222 arrives mid-frame.
    bus.dp = 4'b0100;
    at(700, "dp_shadowed",  lit(4'b1011, S2, 1'b1));
    bus.data = 16'h1111;
    go(840); bus.data = 16'h2222;
    at(898, "tear_d2",      lit(4'b1011, S1, 1'b0));
    at(962, "tear_d3",      lit(4'b0111, S1, 1'b1));
    ft_at(1023, 1'b1);
    at(1026, "new_d0",      lit(4'b1110, S2, 1'b1));
    at(1090, "new_d1",      lit(4'b1101, S2, 1'b1));

    // Leading-zero suppression.
    go(1100);
    bus.lz_blank = 1'b1;
    bus.data     = 16'h0050;
    bus.dp       = 4'b0000;
    at(1282, "lz_d0",       lit(4'b1110, S0, 1'b1));
    at(1346, "lz_d1",       lit(4'b1101, S5, 1'b1));
    at(1410, "lz_d2",       DARK);
    at(1474, "lz_d3",       DARK);
    go(1480);
    bus.data = 16'h0000;
    bus.dp   = 4'b1000;
    at(1538, "lz0_d0",      lit(4'b1110, S0, 1'b1));
    at(1602, "lz0_d1",      DARK);
    at(1666, "lz0_d2",      DARK);
    at(1730, "lz0_d3_dp",   lit(4'b0111, 7'h7F, 1'b0));

    // Blink on digit 0; phase is 1 in frames 6-7, 10-11 and 0 in 8-9, 12.
    go(1740);
    bus.lz_blank   = 1'b0;
    bus.dp         = 4'b0000;
    bus.data       = 16'h1234;
    bus.blink_mask = 4'b0001;
    at(1794, "blink_f7",    DARK);
    at(1858, "blink_other", lit(4'b1101, S3, 1'b1));
    at(2050, "blink_f8",    lit(4'b1110, S4, 1'b1));
    at(2306, "blink_f9",    lit(4'b1110, S4, 1'b1));
    at(2562, "blink_f10",   DARK);
    at(2818, "blink_f11",   DARK);
    at(2882, "blink_oth2",  lit(4'b1101, S3, 1'b1));
    at(3074, "blink_f12",   lit(4'b1110, S4, 1'b1));

    // Reset in the middle of digit 2's lit window.
    at(3210, "pre_reset",   lit(4'b1011, S2, 1'b1));
    rst_n = 1'b0;
    #1;
    chk("midreset_outs", {bus.anodes, bus.seg, bus.dp_n}, DARK);
    chk("midreset_ft", {11'b0, bus.frame_tick}, 12'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    at(1,  "restart_blank", DARK);
    at(2,  "restart_d0",    lit(4'b1110, S0, 1'b1));
    at(66, "restart_d1",    lit(4'b1101, S0, 1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
